// File: rtl/bz_input_conditioner.sv
// -----------------------------------------------------------------------------
// bz_input_conditioner
//
// Turns raw MiSTer joystick/analog words into the arcade cabinet signals
// consumed by the Battlezone / Bradley Trainer / Red Baron core.
//
// Each joystick bit takes this path:
//   two-flop synchroniser -> per-bit debouncer -> (coin only) coin-mech pulse
//   shaper -> game-specific output mapping -> output register
// The analog word and the axis select are registered once and used as they are.
//
// Ports
//   clk_i            in   system clock (50 MHz)
//   btnCpuReset      in   asynchronous active-low reset
//   joy[15:0]        in   raw joystick: [0]R [1]L [2]D [3]U [4]fire
//                         [5]start1 [6]start2 [7]coin; [15:8] unused
//   joya[15:0]       in   raw analog: [7:0] X signed, [15:8] Y signed
//   audiosel         in   analog axis select from the core (1 = X, 0 = Y)
//   mod_battlezone   in   game select
//   mod_bradley      in   game select
//   mod_redbaron     in   game select (highest priority)
//   JB[7:0]          out  core JB bus
//   buttons[7:0]     out  Pokey button / analog byte
//   REDBARONBUTTONS  out  Red Baron fire/start
// -----------------------------------------------------------------------------
module bz_input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int COIN_PULSE_CYCLES = 1500000,
    parameter int COIN_GAP_CYCLES   = 1500000
) (
    input  logic        clk_i,
    input  logic        btnCpuReset,
    input  logic [15:0] joy,
    input  logic [15:0] joya,
    input  logic        audiosel,
    input  logic        mod_battlezone,
    input  logic        mod_bradley,
    input  logic        mod_redbaron,
    output logic [7:0]  JB,
    output logic [7:0]  buttons,
    output logic [7:0]  REDBARONBUTTONS
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int COIN_MAX = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                              COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
    localparam int CW = (COIN_MAX > 2) ? $clog2(COIN_MAX) : 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP_CYCLES - 1);

    localparam int B_R      = 0;
    localparam int B_L      = 1;
    localparam int B_D      = 2;
    localparam int B_U      = 3;
    localparam int B_FIRE   = 4;
    localparam int B_START1 = 5;
    localparam int B_START2 = 6;
    localparam int B_COIN   = 7;

    typedef enum logic [1:0] {
        C_IDLE,
        C_PULSE,
        C_GAP,
        C_WAIT_REL
    } coin_state_e;

    typedef enum logic [1:0] {
        MODE_BZ,
        MODE_BRADLEY,
        MODE_RB
    } mode_e;

    // Stick {U,D,L,R} -> tread controls {WF,WB,XF,XB}.
    function automatic logic [3:0] tread_decode(input logic [3:0] udlr);
        logic [3:0] t;
        case (udlr)
            4'b1010: t = 4'b0010;  // up-left
            4'b1000: t = 4'b1010;  // up
            4'b1001: t = 4'b1000;  // up-right
            4'b0001: t = 4'b1001;  // right
            4'b0101: t = 4'b0100;  // down-right
            4'b0100: t = 4'b0101;  // down
            4'b0110: t = 4'b0001;  // down-left
            4'b0010: t = 4'b0110;  // left
            default: t = 4'b0000;
        endcase
        return t;
    endfunction

    // Two's-complement axis -> offset binary (-128 -> 0x00, +127 -> 0xFF).
    function automatic logic [7:0] rebias_axis(input logic [7:0] axis);
        return axis + 8'd128;
    endfunction

    logic [7:0]      sync1_q, sync2_q;
    logic [7:0]      deb_q, deb_d;
    logic [DB_W-1:0] db_cnt_q [8];
    logic [DB_W-1:0] db_cnt_d [8];
    logic [15:0]     joya_q;
    logic            asel_q;
    logic [1:0]      fill_q, fill_d;
    logic            armed_q, armed_d;
    coin_state_e     state_q, state_d;
    logic [CW-1:0]   coin_cnt_q, coin_cnt_d;
    logic            coin_rise;
    logic            coin_p;
    mode_e           mode;
    logic [3:0]      tread;
    logic [7:0]      axis;
    logic [7:0]      jb_q, jb_d;
    logic [7:0]      btn_q, btn_d;
    logic [7:0]      rbb_q, rbb_d;
    logic            unused_joy_hi;

    assign unused_joy_hi = ^joy[15:8];

    // Debounce: a bit follows its synchronised input only after the two
    // have disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        deb_d = deb_q;
        for (int b = 0; b < 8; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] != deb_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    // The synchroniser comes out of reset holding zeros, which would look
    // like a released coin. fill_q marks when sync2_q carries real samples;
    // only a genuinely released coin arms the shaper, so a coin held through
    // reset has to be released and pressed again.
    always_comb begin
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~sync2_q[B_COIN]);
    end

    // Rise is taken from the debouncer's next value so the coin pulse has
    // the same latency as every other input.
    assign coin_rise = deb_d[B_COIN] & ~deb_q[B_COIN] & armed_q;

    always_comb begin
        state_d    = state_q;
        coin_cnt_d = coin_cnt_q;
        case (state_q)
            C_IDLE: begin
                if (coin_rise) begin
                    state_d    = C_PULSE;
                    coin_cnt_d = '0;
                end
            end
            C_PULSE: begin
                if (coin_cnt_q == PULSE_LAST) begin
                    state_d    = C_GAP;
                    coin_cnt_d = '0;
                end else begin
                    coin_cnt_d = coin_cnt_q + CW'(1);
                end
            end
            C_GAP: begin
                if (coin_cnt_q == GAP_LAST) begin
                    state_d    = C_WAIT_REL;
                    coin_cnt_d = '0;
                end else begin
                    coin_cnt_d = coin_cnt_q + CW'(1);
                end
            end
            C_WAIT_REL: begin
                // A press landing on the same edge as the release check
                // would otherwise be lost in IDLE.
                if (!deb_q[B_COIN]) begin
                    state_d    = coin_rise ? C_PULSE : C_IDLE;
                    coin_cnt_d = '0;
                end
            end
            default: begin
                state_d    = C_IDLE;
                coin_cnt_d = '0;
            end
        endcase
    end

    assign coin_p = (state_q == C_PULSE);

    // Red Baron wins over Bradley, Bradley over Battlezone; with no game
    // selected the Battlezone mapping is used.
    always_comb begin
        if (mod_redbaron) begin
            mode = MODE_RB;
        end else if (mod_bradley) begin
            mode = MODE_BRADLEY;
        end else if (mod_battlezone) begin
            mode = MODE_BZ;
        end else begin
            mode = MODE_BZ;
        end
    end

    assign tread = tread_decode({deb_q[B_U], deb_q[B_D], deb_q[B_L], deb_q[B_R]});
    assign axis  = asel_q ? joya_q[7:0] : joya_q[15:8];

    always_comb begin
        jb_d  = '0;
        btn_d = '0;
        rbb_d = '0;
        case (mode)
            MODE_RB: begin
                // Red Baron's coin input is active low.
                jb_d  = {~coin_p, deb_q[B_START1], deb_q[B_START2], deb_q[B_FIRE],
                         deb_q[B_D], deb_q[B_U], deb_q[B_R], deb_q[B_L]};
                btn_d = rebias_axis(axis);
                rbb_d = {deb_q[B_FIRE], deb_q[B_START1], 6'b000000};
            end
            default: begin
                jb_d  = {coin_p, deb_q[B_START1], deb_q[B_START2], deb_q[B_FIRE], tread};
                btn_d = {2'b00, deb_q[B_START1], deb_q[B_START2] | deb_q[B_FIRE], tread};
                rbb_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            for (int b = 0; b < 8; b++) begin
                db_cnt_q[b] <= '0;
            end
            joya_q     <= '0;
            asel_q     <= 1'b0;
            fill_q     <= '0;
            armed_q    <= 1'b0;
            state_q    <= C_IDLE;
            coin_cnt_q <= '0;
            jb_q       <= '0;
            btn_q      <= '0;
            rbb_q      <= '0;
        end else begin
            sync1_q    <= joy[7:0];
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int b = 0; b < 8; b++) begin
                db_cnt_q[b] <= db_cnt_d[b];
            end
            joya_q     <= joya;
            asel_q     <= audiosel;
            fill_q     <= fill_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            coin_cnt_q <= coin_cnt_d;
            jb_q       <= jb_d;
            btn_q      <= btn_d;
            rbb_q      <= rbb_d;
        end
    end

    assign JB              = jb_q;
    assign buttons         = btn_q;
    assign REDBARONBUTTONS = rbb_q;

endmodule

// File: tb/tb_bz_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_bz_input_conditioner
//
// Drives directed scenarios followed by random joystick/analog traffic into
// bz_input_conditioner and compares every output cycle with a behavioural
// model. Literal checks on hand-computed values pin the model as well.
// -----------------------------------------------------------------------------
module tb_bz_input_conditioner;

    localparam int D = 4;
    localparam int P = 8;
    localparam int G = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] joy = 16'h0000;
    logic [15:0] joya = 16'h0000;
    logic        audiosel = 1'b0;
    logic        mbz = 1'b1;
    logic        mbr = 1'b0;
    logic        mrb = 1'b0;
    logic [7:0]  JB;
    logic [7:0]  buttons;
    logic [7:0]  RBB;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    bz_input_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .COIN_PULSE_CYCLES (P),
        .COIN_GAP_CYCLES   (G)
    ) dut (
        .clk_i           (clk),
        .btnCpuReset     (rst_n),
        .joy             (joy),
        .joya            (joya),
        .audiosel        (audiosel),
        .mod_battlezone  (mbz),
        .mod_bradley     (mbr),
        .mod_redbaron    (mrb),
        .JB              (JB),
        .buttons         (buttons),
        .REDBARONBUTTONS (RBB)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    //   synced stream  = raw stream delayed two edges (zeros after reset)
    //   debounced bit  = flips once the last D synced samples all disagree
    //   coin pulse     = starts on an armed debounced rise, provided the
    //                    previous pulse and its gap are over; lasts P edges
    //   outputs        = mapping of the state before the edge, mode now
    // ------------------------------------------------------------------
    logic [3:0]  tread_tab [16];
    logic [7:0]  dly [$];
    logic [7:0]  win [$];
    logic [7:0]  m_deb;
    bit          m_armed;
    bit          m_has;
    int          m_s;
    int          m_k;
    logic [15:0] m_joya;
    logic        m_asel;
    logic [7:0]  exp_jb, exp_btn, exp_rb;

    initial begin
        for (int i = 0; i < 16; i++) tread_tab[i] = 4'b0000;
        tread_tab[4'b1010] = 4'b0010;
        tread_tab[4'b1000] = 4'b1010;
        tread_tab[4'b1001] = 4'b1000;
        tread_tab[4'b0001] = 4'b1001;
        tread_tab[4'b0101] = 4'b0100;
        tread_tab[4'b0100] = 4'b0101;
        tread_tab[4'b0110] = 4'b0001;
        tread_tab[4'b0010] = 4'b0110;
    end

    task automatic model_reset();
        dly.delete();
        win.delete();
        m_deb   = 8'h00;
        m_armed = 1'b0;
        m_has   = 1'b0;
        m_s     = 0;
        m_k     = 1;
        m_joya  = 16'h0000;
        m_asel  = 1'b0;
        exp_jb  = 8'h00;
        exp_btn = 8'h00;
        exp_rb  = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0] syn;
        bit         syn_v;
        logic [7:0] nd;
        bit         c_old;
        bit         all_diff;
        logic [3:0] tr;
        logic [7:0] ax;
        c_old = m_has && (m_k - 1 >= m_s) && (m_k - 1 <= m_s + P - 1);
        tr = tread_tab[m_deb[3:0]];
        if (mrb) begin
            ax      = m_asel ? m_joya[7:0] : m_joya[15:8];
            exp_jb  = {~c_old, m_deb[5], m_deb[6], m_deb[4], m_deb[2], m_deb[3], m_deb[0], m_deb[1]};
            exp_btn = 8'($signed(ax) + 128);
            exp_rb  = {m_deb[4], m_deb[5], 6'b000000};
        end else begin
            exp_jb  = {c_old, m_deb[5], m_deb[6], m_deb[4], tr};
            exp_btn = {2'b00, m_deb[5], m_deb[6] | m_deb[4], tr};
            exp_rb  = 8'h00;
        end
        if (dly.size() == 2) begin
            syn   = dly.pop_front();
            syn_v = 1'b1;
        end else begin
            syn   = 8'h00;
            syn_v = 1'b0;
        end
        dly.push_back(joy[7:0]);
        win.push_back(syn);
        if (win.size() > D) void'(win.pop_front());
        nd = m_deb;
        if (win.size() == D) begin
            for (int b = 0; b < 8; b++) begin
                all_diff = 1'b1;
                foreach (win[i]) if (win[i][b] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) nd[b] = ~m_deb[b];
            end
        end
        if (nd[7] && !m_deb[7] && m_armed && (!m_has || m_k >= m_s + P + G + 1)) begin
            m_has = 1'b1;
            m_s   = m_k;
        end
        if (syn_v && !syn[7]) m_armed = 1'b1;
        m_deb  = nd;
        m_joya = joya;
        m_asel = audiosel;
        m_k++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            vectors++;
            if ({JB, buttons, RBB} !== {exp_jb, exp_btn, exp_rb}) begin
                miscompares++;
                $display("FAIL model t=%0t: JB/buttons/RB got %h/%h/%h expected %h/%h/%h",
                         $time, JB, buttons, RBB, exp_jb, exp_btn, exp_rb);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Holds joy[7:0]=joyv for n cycles while counting coin-active cycles and
    // coin rising edges seen on JB[7] (Battlezone polarity).
    task automatic run_watch(input int n, input logic [7:0] joyv, output int ones, output int rises);
        logic prev;
        prev  = JB[7];
        joy   = {8'h00, joyv};
        ones  = 0;
        rises = 0;
        repeat (n) begin
            @(negedge clk);
            if (JB[7]) ones++;
            if (JB[7] && !prev) rises++;
            prev = JB[7];
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ones, rises, o2, r2, o3, r3, n;

        repeat (3) @(negedge clk);
        check("reset_jb", int'(JB), 8'h00);
        check("reset_btn", int'(buttons), 8'h00);
        check("reset_rb", int'(RBB), 8'h00);
        check_en = 1'b1;
        rst_n = 1'b1;

        @(negedge clk);
        check("bz_idle_jb", int'(JB), 8'h00);
        check("bz_idle_btn", int'(buttons), 8'h00);
        mrb = 1'b1;
        @(negedge clk);
        check("rb_switch_jb", int'(JB), 8'h80);
        mrb = 1'b0;
        @(negedge clk);

        // Stick decode and exact latency
        joy = 16'h0008;
        repeat (6) @(negedge clk);
        check("up_before_latency", int'(JB), 8'h00);
        @(negedge clk);
        check("up_jb", int'(JB), 8'h0A);
        check("up_btn", int'(buttons), 8'h0A);
        joy = 16'h0009;
        repeat (7) @(negedge clk);
        check("upright_jb", int'(JB), 8'h08);
        joy = 16'h000F;
        repeat (7) @(negedge clk);
        check("all_dirs_jb", int'(JB), 8'h00);
        joy = 16'h0000;
        repeat (8) @(negedge clk);

        // Fire glitch rejected, held fire accepted
        joy = 16'h0010;
        repeat (3) @(negedge clk);
        joy = 16'h0000;
        ones = 0;
        repeat (10) begin
            @(negedge clk);
            if (JB[4]) ones++;
        end
        check("fire_glitch", ones, 0);
        joy = 16'h0010;
        repeat (7) @(negedge clk);
        check("fire_jb", int'(JB), 8'h10);
        check("fire_btn", int'(buttons), 8'h10);
        repeat (3) @(negedge clk);
        joy = 16'h0000;
        repeat (8) @(negedge clk);

        // Coin held: one pulse of exactly P cycles
        run_watch(100, 8'h80, ones, rises);
        check("coin_hold_width", ones, P);
        check("coin_hold_count", rises, 1);
        run_watch(20, 8'h00, ones, rises);
        // Re-press during the gap is ignored until released after the gap
        run_watch(10, 8'h80, ones, rises);
        run_watch(5, 8'h00, o2, r2);
        run_watch(30, 8'h80, o3, r3);
        check("coin_gap_count", rises + r2 + r3, 1);
        check("coin_gap_width", ones + o2 + o3, P);
        run_watch(10, 8'h00, ones, rises);
        run_watch(20, 8'h80, ones, rises);
        check("coin_second_count", rises, 1);
        check("coin_second_width", ones, P);
        run_watch(20, 8'h00, ones, rises);

        // Red Baron analog rebias and buttons
        mrb = 1'b1;
        joya = 16'h7F81;
        audiosel = 1'b1;
        repeat (2) @(negedge clk);
        check("rb_axis_x", int'(buttons), 8'h01);
        audiosel = 1'b0;
        @(negedge clk);
        check("rb_axis_lag", int'(buttons), 8'h01);
        @(negedge clk);
        check("rb_axis_y", int'(buttons), 8'hFF);
        joya = 16'h8000;
        repeat (2) @(negedge clk);
        check("rb_axis_min", int'(buttons), 8'h00);
        joya = 16'h0000;
        repeat (2) @(negedge clk);
        check("rb_axis_zero", int'(buttons), 8'h80);
        joy = 16'h0030;
        repeat (7) @(negedge clk);
        check("rb_buttons", int'(RBB), 8'hC0);
        check("rb_jb", int'(JB), 8'hD0);
        joy = 16'h0000;
        repeat (8) @(negedge clk);
        mrb = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a coin pulse
        joy = 16'h0080;
        n = 0;
        while (JB[7] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("coin_start_timeout", int'(n < 20), 1);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_jb", int'(JB), 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_watch(30, 8'h80, ones, rises);
        check("held_after_reset", rises, 0);
        run_watch(10, 8'h00, ones, rises);
        run_watch(20, 8'h80, ones, rises);
        check("repress_after_reset", rises, 1);
        check("repress_width", ones, P);
        run_watch(20, 8'h00, ones, rises);

        // Random traffic
        for (int seg = 0; seg < 400; seg++) begin
            int len;
            len = $urandom_range(1, 14);
            joy = 16'($urandom);
            joy[7] = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) begin
                {mrb, mbr, mbz} = 3'($urandom);
            end
            repeat (len) begin
                @(negedge clk);
                joya = 16'($urandom);
                audiosel = 1'($urandom);
            end
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        joy = 16'h0000;
        repeat (10) @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
